spi_slave_regs: RTL and testbench
=================================

SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of 8-bit read/write registers (2..127).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on SPI inputs (2..3).
REQ-003 SYS_CLK_80M  input  1  single system clock; all logic on rising edge.
REQ-004 Peripheral_rst  input  1  synchronous, active-high reset.
REQ-005 spi_ss_n  input  1  slave select, active low.
REQ-006 spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), at most SYS_CLK_80M/8.
REQ-007 spi_mosi  input  1  master-out data, MSB first.
REQ-008 spi_miso  output  1  slave-out data, MSB first.
REQ-009 spi_miso_oe  output  1  MISO output enable for the top-level tristate.
REQ-010 status_in  input  8  read-only value returned at address 0x7F.
REQ-011 ctrl_out  output  8  current contents of register 0.
REQ-012 reg_wr_stb  output  1  one-cycle pulse per committed write.
REQ-013 reg_wr_addr  output  7  address of committed write.
REQ-014 reg_wr_data  output  8  data of committed write.

Function
REQ-015 spi_ss_n, spi_sck and spi_mosi SHALL pass through SYNC_STAGES flops; SCK edges are detected on synchronized samples; all SPI-side latencies are counted from synchronized edges.
REQ-016 Frame: byte 0 = command {rw, addr[6:0]}, rw=1 read, rw=0 write; byte 1 = data.
REQ-017 FSM states IDLE, CMD, DATA, DONE; IDLE->CMD on synchronized ss_n falling; CMD->DATA after 8th SCK rise; DATA->DONE after 8th data-byte SCK rise; any state->IDLE on ss_n rising.
REQ-018 MOSI SHALL be sampled on synchronized SCK rising edge; MISO SHALL update one SYS_CLK cycle after synchronized SCK falling edge.
REQ-019 Read: on 8th command rise, data byte SHALL load into the TX shifter and its MSB SHALL appear on spi_miso within 2 SYS_CLK cycles, before the first data-byte rise.
REQ-020 Read data: addr < NREGS -> register; addr 0x7F -> status_in sampled at load; other addresses -> 0x00.
REQ-021 spi_miso SHALL be 0 during CMD, DONE and IDLE; spi_miso_oe = 1 exactly while synchronized ss_n is low.
REQ-022 Write: on 8th data-byte rise, if addr < NREGS register SHALL update and reg_wr_stb SHALL pulse on the next cycle with addr/data; addr >= NREGS SHALL be ignored with no strobe.
REQ-023 ss_n rising mid-byte SHALL abort: partial byte discarded, no write, bit counter cleared.
REQ-024 SCK edges while ss_n is high SHALL be ignored.
REQ-025 In DONE, further bytes SHALL be clocked in and discarded (unless REQ-030 applies).
REQ-026 reg_wr_addr/reg_wr_data SHALL hold the last committed write between strobes.

Reset
REQ-027 On Peripheral_rst: FSM=IDLE, bit counter=0, all registers=0x00, ctrl_out=0x00, spi_miso=0, spi_miso_oe=0, reg_wr_stb=0, reg_wr_addr=0, reg_wr_data=0, synchronizers loaded with ss_n=1, sck=0, mosi=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without a write; after release the block SHALL wait for a fresh ss_n falling edge.

Configuration
REQ-029 Macro SPI_SLAVE_AUTO_INC_EN selects burst mode.
REQ-030 Defined: after each data byte the FSM SHALL stay in DATA with address+1 (wrapping 0x7E->0x00, skipping 0x7F for writes); reads preload the next address on the 8th rise; DONE is unused.
REQ-031 Undefined: single-byte transfers only, per REQ-025.

Verification
REQ-032 Write 0x03,0xA5 -> reg_wr_stb one pulse, addr=0x03, data=0xA5; register 3 reads back 0xA5.
REQ-033 Write 0x00,0x5C -> ctrl_out=0x5C one cycle after strobe.
REQ-034 status_in=0x3C, read 0xFF -> MISO byte 0x3C; read 0x90 (addr 0x10, NREGS=16) -> 0x00.
REQ-035 Write 0x02,0x77 with ss_n raised after 5 data bits -> no strobe, register 2 unchanged; next full write succeeds.
REQ-036 Reset asserted between command and data bytes -> all outputs at reset values, no strobe, register 1 = 0x00.
REQ-037 With SPI_SLAVE_AUTO_INC_EN, write 0x0E,0x11,0x22,0x33 -> regs 14,15 = 0x11,0x22, 0x33 dropped (addr 0x10 >= NREGS); without macro only reg 14 written.

Source files
------------

// File: rtl/spi_slave_regs.sv
// spi_slave_regs
//   SPI mode-0 slave exposing NREGS 8-bit read/write registers plus one
//   read-only status byte at address 0x7F. All logic runs on SYS_CLK_80M.
//   The SPI pins are oversampled through synchronizers, and SCK edges are
//   detected on the synchronized samples.
//
//   Frame: byte 0 = {rw, addr[6:0]} (rw=1 read), byte 1 = data.
//
// Parameters
//   NREGS        number of read/write registers (2..127)
//   SYNC_STAGES  synchronizer depth on spi_ss_n / spi_sck / spi_mosi (2..3)
//
// Build option
//   SPI_SLAVE_AUTO_INC_EN  when defined, the data phase continues as a burst.
//                          The address increments after each byte and wraps
//                          from 0x7E to 0x00. When undefined, each frame
//                          carries a single data byte, and extra bytes are
//                          clocked in and discarded.
//
// Ports
//   SYS_CLK_80M     system clock, rising edge
//   Peripheral_rst  synchronous active-high reset
//   spi_ss_n        slave select, active low
//   spi_sck         SPI clock (CPOL=0, CPHA=0), at most SYS_CLK_80M/8
//   spi_mosi        master-out data, MSB first
//   spi_miso        slave-out data, MSB first (0 outside the read data phase)
//   spi_miso_oe     tristate enable, high while synchronized ss_n is low
//   status_in       value returned for reads of address 0x7F
//   ctrl_out        contents of register 0
//   reg_wr_stb      one-cycle pulse per committed register write
//   reg_wr_addr     address of the last committed write (held between pulses)
//   reg_wr_data     data of the last committed write (held between pulses)
//   dbg_state       current FSM state (0=IDLE 1=CMD 2=DATA 3=DONE)
//
// Write notification: reg_wr_stb is a single-cycle qualifier with no
// back-pressure. reg_wr_addr/reg_wr_data are valid in the same cycle the
// strobe is high, and they stay stable until the next strobe.

module spi_slave_regs #(
  parameter int NREGS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       SYS_CLK_80M,
  input  logic       Peripheral_rst,
  input  logic       spi_ss_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] status_in,
  output logic [7:0] ctrl_out,
  output logic       reg_wr_stb,
  output logic [6:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int         AW      = $clog2(NREGS);
  localparam logic [7:0] NREGS_B = 8'(NREGS);
  localparam logic [6:0] STATUS_ADDR = 7'h7F;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_s, sck_s, mosi_s;
  logic                   ss_d, sck_d;
  // Counts the cycles after reset until the synchronizer chain holds real
  // pin samples. A slave select that was already low across reset must not
  // look like a fresh falling edge.
  logic [2:0]             flush_cnt;
  logic                   sync_ok;

  logic                   ss_fall, sck_rise, sck_fall;

  // FSM and datapath
  state_t                 state, state_next;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_in;
  logic [7:0]             rx_byte;
  logic                   byte_done;
  logic                   cmd_rw;
  logic [6:0]             addr;
  logic [6:0]             addr_next;
  logic [6:0]             rd_addr;
  logic [7:0]             rd_data;
  logic [7:0]             tx_shift;
  logic                   miso_q;
  logic                   addr_in_range;

  logic [7:0]             regs [NREGS];

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sync_ok  = flush_cnt[2];
  assign ss_fall  = sync_ok & ss_d & ~ss_s;
  // SCK edges only count while the slave is selected.
  assign sck_rise = ~ss_s & sck_s & ~sck_d;
  assign sck_fall = ~ss_s & ~sck_s & sck_d;

  // The byte completes on the rise that samples its last bit, so include
  // the current MOSI sample.
  assign rx_byte   = {shift_in[6:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE);

  // The burst address sequence skips 0x7F, which is the read-only status.
  assign addr_next     = (addr >= 7'h7E) ? 7'h00 : addr + 7'd1;
  assign addr_in_range = ({1'b0, addr} < NREGS_B);

  // Read-data source. In CMD the address comes straight off the wire. In
  // DATA it is the next burst address, preloaded on the last rise.
  always_comb begin
    rd_addr = (state == CMD) ? rx_byte[6:0] : addr_next;
    rd_data = 8'h00;
    if ({1'b0, rd_addr} < NREGS_B) begin
      rd_data = regs[rd_addr[AW-1:0]];
    end else if (rd_addr == STATUS_ADDR) begin
      rd_data = status_in;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (ss_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_next = CMD;
        CMD:  if (byte_done) state_next = DATA;
`ifdef SPI_SLAVE_AUTO_INC_EN
        DATA: state_next = DATA;
`else
        DATA: if (byte_done) state_next = DONE;
`endif
        DONE: state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge SYS_CLK_80M) begin
    if (Peripheral_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Synchronizers, bit counter, shifters and the register file
  always_ff @(posedge SYS_CLK_80M) begin
    if (Peripheral_rst) begin
      ss_sync     <= '1;
      sck_sync    <= '0;
      mosi_sync   <= '0;
      ss_d        <= 1'b1;
      sck_d       <= 1'b0;
      flush_cnt   <= 3'd0;
      bit_cnt     <= 3'd0;
      shift_in    <= 8'h00;
      cmd_rw      <= 1'b0;
      addr        <= 7'h00;
      tx_shift    <= 8'h00;
      miso_q      <= 1'b0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= 7'h00;
      reg_wr_data <= 8'h00;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_d      <= ss_s;
      sck_d     <= sck_s;
      if (!flush_cnt[2]) begin
        flush_cnt <= flush_cnt + 3'd1;
      end

      reg_wr_stb <= 1'b0;

      // Leaving the frame, or never having entered it, drops any partial byte.
      if (ss_s || state == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= rx_byte;
      end

      if (ss_s || state == IDLE) begin
        miso_q <= 1'b0;
      end else if (state == CMD && byte_done) begin
        cmd_rw <= rx_byte[7];
        addr   <= rx_byte[6:0];
        if (rx_byte[7]) begin
          // The MSB goes out right away, so the master sees it on the first
          // data rise.
          miso_q   <= rd_data[7];
          tx_shift <= {rd_data[6:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end else if (state == DATA && byte_done) begin
        if (!cmd_rw && addr_in_range) begin
          regs[addr[AW-1:0]] <= rx_byte;
          reg_wr_stb         <= 1'b1;
          reg_wr_addr        <= addr;
          reg_wr_data        <= rx_byte;
        end
`ifdef SPI_SLAVE_AUTO_INC_EN
        addr <= addr_next;
        if (cmd_rw) begin
          miso_q   <= rd_data[7];
          tx_shift <= {rd_data[6:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
`else
        miso_q <= 1'b0;
`endif
      end else if (state == DATA && cmd_rw && sck_fall && bit_cnt != 3'd0) begin
        // bit_cnt == 0 marks the fall just after the MSB was preloaded. That
        // bit must stay on the line until the next rise samples it.
        miso_q   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~ss_s;
  assign ctrl_out    = regs[0];
  assign dbg_state   = state;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs
//   Directed bench for spi_slave_regs (NREGS=16, SYNC_STAGES=2). It acts as
//   an SPI mode-0 master with SCK at SYS_CLK/16. A monitor collects
//   committed writes into obs_q. Each test fills exp_q by hand and compares
//   the two queues inline.

`timescale 1ns/1ps

module tb_spi_slave_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] status_in = 8'h00;
  logic [7:0] ctrl_out;
  logic       reg_wr_stb;
  logic [6:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];

  spi_slave_regs #(.NREGS(16), .SYNC_STAGES(2)) dut (
    .SYS_CLK_80M   (clk),
    .Peripheral_rst(rst),
    .spi_ss_n      (spi_ss_n),
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .status_in     (status_in),
    .ctrl_out      (ctrl_out),
    .reg_wr_stb    (reg_wr_stb),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .dbg_state     (dbg_state)
  );

  // Clock and reset
  always #6.25 clk = ~clk;

  // Write monitor. It samples on the falling edge, so every high cycle of
  // the strobe adds one entry.
  always @(negedge clk) begin
    if (reg_wr_stb === 1'b1) obs_q.push_back({reg_wr_addr, reg_wr_data});
  end

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_open();
    spi_ss_n = 1'b0;
    cyc(8);
  endtask

  task automatic ss_close();
    cyc(8);
    spi_ss_n = 1'b1;
    cyc(8);
  endtask

  // Shifts nbits of tx MSB first. MISO is captured just before each rise,
  // which is where a mode-0 master samples it.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      cyc(4);
      rx[7-i] = spi_miso;
      spi_sck = 1'b1;
      cyc(8);
      spi_sck = 1'b0;
      cyc(4);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rx;
    ss_open();
    xfer({1'b0, a}, 8, rx);
    xfer(d, 8, rx);
    ss_close();
  endtask

  task automatic do_read(input logic [6:0] a, output logic [7:0] cmd_rx, output logic [7:0] data_rx);
    ss_open();
    xfer({1'b1, a}, 8, cmd_rx);
    xfer(8'h00, 8, data_rx);
    ss_close();
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_vec++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    n_vec++; if (spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b expected 0", spi_miso_oe); end
    n_vec++; if (reg_wr_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b expected 0", reg_wr_stb); end
    n_vec++; if (reg_wr_addr !== 7'h00) begin n_bad++; $display("FAIL reset_wr_addr: got %h expected 00", reg_wr_addr); end
    n_vec++; if (reg_wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_data: got %h expected 00", reg_wr_data); end
    n_vec++; if (ctrl_out !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl: got %h expected 00", ctrl_out); end
    n_vec++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    cyc(6);
  endtask

  task automatic test_write();
    logic [7:0] rx, cmd_rx, data_rx;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({7'h03, 8'hA5});
    ss_open();
    n_vec++; if (spi_miso_oe !== 1'b1) begin n_bad++; $display("FAIL write_oe_low: got %b expected 1", spi_miso_oe); end
    n_vec++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL write_state_cmd: got %0d expected 1", dbg_state); end
    xfer(8'h03, 8, rx);
    n_vec++; if (rx !== 8'h00) begin n_bad++; $display("FAIL write_cmd_miso: got %h expected 00", rx); end
    n_vec++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL write_state_data: got %0d expected 2", dbg_state); end
    xfer(8'hA5, 8, rx);
`ifdef SPI_SLAVE_AUTO_INC_EN
    n_vec++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL write_state_end: got %0d expected 2", dbg_state); end
`else
    n_vec++; if (dbg_state !== 2'd3) begin n_bad++; $display("FAIL write_state_end: got %0d expected 3", dbg_state); end
`endif
    ss_close();
    n_vec++; if (spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL write_oe_high: got %b expected 0", spi_miso_oe); end
    n_vec++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL write_state_idle: got %0d expected 0", dbg_state); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL write_stb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL write_stb_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (reg_wr_addr !== 7'h03) begin n_bad++; $display("FAIL write_hold_addr: got %h expected 03", reg_wr_addr); end
    n_vec++; if (reg_wr_data !== 8'hA5) begin n_bad++; $display("FAIL write_hold_data: got %h expected a5", reg_wr_data); end
    do_read(7'h03, cmd_rx, data_rx);
    n_vec++; if (cmd_rx !== 8'h00) begin n_bad++; $display("FAIL read3_cmd_miso: got %h expected 00", cmd_rx); end
    n_vec++; if (data_rx !== 8'hA5) begin n_bad++; $display("FAIL read3_data: got %h expected a5", data_rx); end
  endtask

  task automatic test_ctrl();
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({7'h00, 8'h5C});
    do_write(7'h00, 8'h5C);
    n_vec++; if (ctrl_out !== 8'h5C) begin n_bad++; $display("FAIL ctrl_out: got %h expected 5c", ctrl_out); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ctrl_stb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ctrl_stb_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_status_read();
    logic [7:0] cmd_rx, data_rx;
    status_in = 8'h3C;
    do_read(7'h7F, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h3C) begin n_bad++; $display("FAIL status_read: got %h expected 3c", data_rx); end
    do_read(7'h10, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h00) begin n_bad++; $display("FAIL read_0x10: got %h expected 00", data_rx); end
    do_read(7'h20, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h00) begin n_bad++; $display("FAIL read_0x20: got %h expected 00", data_rx); end
    do_read(7'h00, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h5C) begin n_bad++; $display("FAIL read_0x00: got %h expected 5c", data_rx); end
  endtask

  task automatic test_abort();
    logic [7:0] rx, cmd_rx, data_rx;
    exp_q.delete(); obs_q.delete();
    ss_open();
    xfer(8'h02, 8, rx);
    xfer(8'h77, 5, rx);
    ss_close();
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL abort_no_stb: got %0d expected 0", obs_q.size()); end
    do_read(7'h02, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h00) begin n_bad++; $display("FAIL abort_reg2: got %h expected 00", data_rx); end
    exp_q.push_back({7'h02, 8'h77});
    do_write(7'h02, 8'h77);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL abort_next_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL abort_next_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    do_read(7'h02, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h77) begin n_bad++; $display("FAIL abort_next_reg2: got %h expected 77", data_rx); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, cmd_rx, data_rx;
    do_write(7'h01, 8'h5A);
    exp_q.delete(); obs_q.delete();
    ss_open();
    xfer(8'h01, 8, rx);
    rst = 1'b1;
    cyc(3);
    n_vec++; if (spi_miso_oe !== 1'b0) begin n_bad++; $display("FAIL rstmid_oe: got %b expected 0", spi_miso_oe); end
    n_vec++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL rstmid_miso: got %b expected 0", spi_miso); end
    n_vec++; if (ctrl_out !== 8'h00) begin n_bad++; $display("FAIL rstmid_ctrl: got %h expected 00", ctrl_out); end
    n_vec++; if (reg_wr_addr !== 7'h00) begin n_bad++; $display("FAIL rstmid_wr_addr: got %h expected 00", reg_wr_addr); end
    n_vec++; if (reg_wr_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_wr_data: got %h expected 00", reg_wr_data); end
    n_vec++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rstmid_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    xfer(8'hAB, 8, rx);
    // ss_n stayed low through reset, so there has been no fresh falling edge.
    n_vec++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rstmid_wait_edge: got %0d expected 0", dbg_state); end
    ss_close();
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rstmid_no_stb: got %0d expected 0", obs_q.size()); end
    do_read(7'h01, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h00) begin n_bad++; $display("FAIL rstmid_reg1: got %h expected 00", data_rx); end
  endtask

  task automatic test_burst();
    logic [7:0] rx, cmd_rx, data_rx;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({7'h0E, 8'h11});
`ifdef SPI_SLAVE_AUTO_INC_EN
    exp_q.push_back({7'h0F, 8'h22});
`endif
    ss_open();
    xfer(8'h0E, 8, rx);
    xfer(8'h11, 8, rx);
    xfer(8'h22, 8, rx);
    n_vec++; if (rx !== 8'h00) begin n_bad++; $display("FAIL burst_miso_quiet: got %h expected 00", rx); end
    xfer(8'h33, 8, rx);
    ss_close();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL burst_stb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL burst_stb_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    do_read(7'h0E, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h11) begin n_bad++; $display("FAIL burst_reg14: got %h expected 11", data_rx); end
    do_read(7'h0F, cmd_rx, data_rx);
`ifdef SPI_SLAVE_AUTO_INC_EN
    n_vec++; if (data_rx !== 8'h22) begin n_bad++; $display("FAIL burst_reg15: got %h expected 22", data_rx); end
`else
    n_vec++; if (data_rx !== 8'h00) begin n_bad++; $display("FAIL burst_reg15: got %h expected 00", data_rx); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmd_rx, data_rx;
    exp_q.delete(); obs_q.delete();
    // SCK activity while deselected must not start a frame.
    spi_mosi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      spi_sck = 1'b1; cyc(4);
      spi_sck = 1'b0; cyc(4);
    end
    n_vec++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL sck_idle_state: got %0d expected 0", dbg_state); end
    n_vec++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL sck_idle_stb: got %0d expected 0", obs_q.size()); end
    exp_q.push_back({7'h05, 8'h3C});
    exp_q.push_back({7'h06, 8'hC3});
    do_write(7'h05, 8'h3C);
    do_write(7'h06, 8'hC3);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_stb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_stb_%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    do_read(7'h05, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'h3C) begin n_bad++; $display("FAIL b2b_reg5: got %h expected 3c", data_rx); end
    do_read(7'h06, cmd_rx, data_rx);
    n_vec++; if (data_rx !== 8'hC3) begin n_bad++; $display("FAIL b2b_reg6: got %h expected c3", data_rx); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ctrl();
    test_status_read();
    test_abort();
    test_reset_mid();
    test_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
